// File: rtl/ex_stage_controller.sv
// ex_stage_controller: EX-stage opcode decode, NZCV flag register and iterative MUL sequencer with pipeline stall
module ex_stage_controller #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             alu_on,
    input  logic [10:0]      opcode,
    input  logic [WIDTH-1:0] mul_a,
    input  logic [WIDTH-1:0] mul_b,
    input  logic [3:0]       alu_flags_in,
    output logic [2:0]       alu_cntrl,
    output logic             illegal_op,
    output logic [3:0]       flags,
    output logic             stall,
    output logic             mul_valid,
    output logic [WIDTH-1:0] mul_result
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       flags_q, flags_d;
    logic is_addi, is_adds, is_ldur, is_stur, is_subs, is_bl, is_cbz, is_mul;
    logic known, accept, busy;
    always_comb begin
        is_addi    = opcode[10:1] == 10'b1001000100;
        is_adds    = opcode == 11'b10101011000;
        is_ldur    = opcode == 11'b11111000010;
        is_stur    = opcode == 11'b11111000000;
        is_subs    = opcode == 11'b11101011000;
        is_bl      = opcode[10:5] == 6'b100101;
        is_cbz     = opcode[10:3] == 8'b10110100;
        is_mul     = opcode == 11'b10011011000;
        known      = is_addi | is_adds | is_ldur | is_stur | is_subs | is_bl | is_cbz | is_mul;
        alu_cntrl  = !alu_on ? 3'b000 :
                     (is_addi | is_adds | is_ldur | is_stur) ? 3'b010 :
                     is_subs ? 3'b011 :
                     is_bl   ? 3'b000 :
                     is_cbz  ? 3'b100 :
                     is_mul  ? 3'b000 : 3'b111;
        illegal_op = valid_in & alu_on & !known;
        busy       = state_q == BUSY;
        accept     = (state_q == IDLE) & valid_in & is_mul & !flush;
        stall      = !flush & (accept | busy);
        mul_valid  = (state_q == DONE) & !flush;
        // The finished product is shown from the accumulator in DONE and latched for later cycles,
        // so a flushed DONE leaves the previously published result visible.
        mul_result = mul_valid ? acc_q : res_q;
        flags      = flags_q;
        state_d    = flush ? IDLE :
                     accept ? BUSY :
                     (busy && cnt_q == CW'(1)) ? DONE :
                     (state_q == DONE) ? IDLE : state_q;
        acc_d      = accept ? '0 : busy ? acc_q + (b_q[0] ? a_q : '0) : acc_q;
        a_d        = accept ? mul_a : busy ? a_q << 1 : a_q;
        b_d        = accept ? mul_b : busy ? b_q >> 1 : b_q;
        cnt_d      = accept ? CW'(WIDTH) : busy ? cnt_q - CW'(1) : cnt_q;
        res_d      = mul_valid ? acc_q : res_q;
        flags_d    = (valid_in & !stall & !flush & (is_adds | is_subs)) ? alu_flags_in : flags_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end
endmodule
